// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator (PRGA): walks the S array in s_memory, swaps entries,
// and XORs each keystream byte with the encrypted ROM byte into the output RAM.
module rc4_prga_decrypt #(
   parameter int MSG_LEN = 32,
   parameter int K_W     = 5
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic [7:0]     s_addr,
   output logic [7:0]     s_wdata,
   output logic           s_wren,
   input  logic [7:0]     s_q,
   output logic [K_W-1:0] rom_addr,
   input  logic [7:0]     rom_q,
   output logic [K_W-1:0] out_addr,
   output logic [7:0]     out_data,
   output logic           out_wren
);

   typedef enum logic [3:0] {
      IDLE, SET_I, WAIT_I, GET_I, WAIT_J, GET_J,
      WR_I, WR_J, WAIT_F, GET_F, NEXT, DONE
   } state_t;

   localparam logic [K_W-1:0] K_LAST = K_W'(MSG_LEN - 1);

   state_t         state;
   logic [7:0]     i, j, si, sj;
   logic [K_W-1:0] k;
   logic           start_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         s_addr   <= '0;
         s_wdata  <= '0;
         s_wren   <= 1'b0;
         rom_addr <= '0;
         out_addr <= '0;
         out_data <= '0;
         out_wren <= 1'b0;
         i        <= '0;
         j        <= '0;
         k        <= '0;
         si       <= '0;
         sj       <= '0;
         start_d  <= 1'b0;
      end else begin
         start_d <= start;
         unique case (state)
            IDLE: begin
               if (start) begin
                  i     <= '0;
                  j     <= '0;
                  k     <= '0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  state <= SET_I;
               end
            end
            SET_I: begin
               i      <= i + 8'd1;
               s_addr <= i + 8'd1;
               s_wren <= 1'b0;
               state  <= WAIT_I;
            end
            WAIT_I: state <= GET_I;
            GET_I: begin
               si     <= s_q;
               j      <= j + s_q;
               s_addr <= j + s_q;
               state  <= WAIT_J;
            end
            WAIT_J: state <= GET_J;
            GET_J: begin
               sj      <= s_q;
               s_addr  <= i;
               s_wdata <= s_q;
               s_wren  <= 1'b1;
               state   <= WR_I;
            end
            WR_I: begin
               s_addr  <= j;
               s_wdata <= si;
               s_wren  <= 1'b1;
               state   <= WR_J;
            end
            // Keystream read is issued only after both swap writes have landed.
            WR_J: begin
               s_addr   <= si + sj;
               s_wren   <= 1'b0;
               rom_addr <= k;
               state    <= WAIT_F;
            end
            WAIT_F: state <= GET_F;
            GET_F: begin
               out_data <= s_q ^ rom_q;
               out_addr <= k;
               out_wren <= 1'b1;
               state    <= NEXT;
            end
            NEXT: begin
               out_wren <= 1'b0;
               if (k == K_LAST) begin
                  state <= DONE;
               end else begin
                  k     <= k + K_W'(1);
                  state <= SET_I;
               end
            end
            // A new run needs a fresh rising start once done is already showing.
            DONE: begin
               s_wren   <= 1'b0;
               out_wren <= 1'b0;
               if (done && start && !start_d) begin
                  i     <= '0;
                  j     <= '0;
                  k     <= '0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  state <= SET_I;
               end else begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench for rc4_prga_decrypt: S RAM / ROM / output RAM models
// around the DUT, outputs compared against a software RC4 PRGA model.
module tb_rc4_prga_decrypt;

   localparam int ML  = 32;
   localparam int KW  = 5;
   localparam int LAT = 10 * ML + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, s_wren, out_wren;
   logic [7:0]    s_addr, s_wdata, s_q, rom_q, out_data;
   logic [KW-1:0] rom_addr, out_addr;

   rc4_prga_decrypt #(.MSG_LEN(ML), .K_W(KW)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_q(s_q),
      .rom_addr(rom_addr), .rom_q(rom_q),
      .out_addr(out_addr), .out_data(out_data), .out_wren(out_wren)
   );

   always #5 clk = ~clk;

   logic [7:0]    s_mem [256];
   logic [7:0]    s_img [256];
   logic [7:0]    rom   [ML];
   logic          load_req = 1'b0;
   logic [15:0]   swr_log [$];
   logic [KW+7:0] out_log [$];

   always @(posedge clk) begin
      if (load_req) begin
         for (int x = 0; x < 256; x++) s_mem[x] <= s_img[x];
      end else if (s_wren) begin
         s_mem[s_addr] <= s_wdata;
      end
      s_q   <= s_mem[s_addr];
      rom_q <= rom[rom_addr];
      if (s_wren)   swr_log.push_back({s_addr, s_wdata});
      if (out_wren) out_log.push_back({out_addr, out_data});
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   logic [7:0] ref_s   [256];
   logic [7:0] ref_out [ML];

   task automatic compute_ref();
      int ii = 0;
      int jj = 0;
      logic [7:0] t;
      for (int x = 0; x < 256; x++) ref_s[x] = s_mem[x];
      for (int n = 0; n < ML; n++) begin
         ii = (ii + 1) % 256;
         jj = (jj + ref_s[ii]) % 256;
         t = ref_s[ii]; ref_s[ii] = ref_s[jj]; ref_s[jj] = t;
         ref_out[n] = ref_s[(ref_s[ii] + ref_s[jj]) % 256] ^ rom[n];
      end
   endtask

   task automatic load_s();
      @(negedge clk); load_req = 1'b1;
      @(negedge clk); load_req = 1'b0;
   endtask

   task automatic set_identity();
      for (int x = 0; x < 256; x++) s_img[x] = 8'(x);
   endtask

   task automatic set_random_perm();
      logic [7:0] t;
      int r;
      set_identity();
      for (int x = 255; x > 0; x--) begin
         r = $urandom_range(x, 0);
         t = s_img[x]; s_img[x] = s_img[r]; s_img[r] = t;
      end
   endtask

   task automatic run(input bit hold, output int lat);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      check("busy_on_accept", busy, 1);
      check("done_clr_accept", done, 0);
      if (!hold) start = 1'b0;
      lat = 0;
      while (!done && lat < LAT + 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("busy_off_done", busy, 0);
   endtask

   task automatic verify(input string tag, input int b_sw, input int b_out);
      logic [KW+7:0] e;
      int mism = 0;
      check({tag, "_out_cnt"}, out_log.size() - b_out, ML);
      check({tag, "_swr_cnt"}, swr_log.size() - b_sw, 2 * ML);
      for (int n = 0; n < ML && b_out + n < out_log.size(); n++) begin
         e = out_log[b_out + n];
         check($sformatf("%s_addr%0d", tag, n), e[KW+7:8], n);
         check($sformatf("%s_byte%0d", tag, n), e[7:0], ref_out[n]);
      end
      for (int x = 0; x < 256; x++) if (s_mem[x] !== ref_s[x]) mism++;
      check({tag, "_s_final_mism"}, mism, 0);
   endtask

   task automatic check_perm(input string tag);
      bit seen [256];
      int distinct = 0;
      for (int x = 0; x < 256; x++) seen[x] = 1'b0;
      for (int x = 0; x < 256; x++) seen[s_mem[x]] = 1'b1;
      for (int x = 0; x < 256; x++) if (seen[x]) distinct++;
      check({tag, "_perm"}, distinct, 256);
   endtask

   function automatic int out_byte(input int idx);
      logic [KW+7:0] e;
      if (idx >= out_log.size()) return -1;
      e = out_log[idx];
      return int'(e[7:0]);
   endfunction

   initial begin
      int lat, b_sw, b_out;
      logic [15:0] w;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_s_wren", s_wren, 0);
      check("rst_out_wren", out_wren, 0);
      check("rst_s_addr", s_addr, 0);
      check("rst_out_data", out_data, 0);
      @(negedge clk); reset = 1'b0;

      // identity S, ROM 0x00: includes i==j on the first byte
      set_identity();
      for (int n = 0; n < ML; n++) rom[n] = 8'h00;
      load_s();
      compute_ref();
      b_sw = swr_log.size(); b_out = out_log.size();
      run(1'b0, lat);
      check("id0_latency", lat, LAT);
      check("id0_b0", out_byte(b_out), 8'h02);
      check("id0_b1", out_byte(b_out + 1), 8'h05);
      check("id0_b2", out_byte(b_out + 2), 8'h07);
      w = (swr_log.size() > b_sw + 1) ? swr_log[b_sw] : 16'hFFFF;
      check("ieqj_wr0", w, 16'h0101);
      w = (swr_log.size() > b_sw + 1) ? swr_log[b_sw + 1] : 16'hFFFF;
      check("ieqj_wr1", w, 16'h0101);
      verify("id0", b_sw, b_out);
      check_perm("id0");

      // identity S, ROM 0xFF: complemented outputs
      set_identity();
      for (int n = 0; n < ML; n++) rom[n] = 8'hFF;
      load_s();
      compute_ref();
      b_sw = swr_log.size(); b_out = out_log.size();
      run(1'b0, lat);
      check("idff_latency", lat, LAT);
      check("idff_b0", out_byte(b_out), 8'hFD);
      check("idff_b1", out_byte(b_out + 1), 8'hFA);
      check("idff_b2", out_byte(b_out + 2), 8'hF8);
      verify("idff", b_sw, b_out);

      // reset during WR_I of byte 1
      set_identity();
      load_s();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      check("mid_in_wr_i", s_wren, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_busy", busy, 0);
      check("mid_done", done, 0);
      check("mid_s_wren", s_wren, 0);
      check("mid_s_addr", s_addr, 0);
      check("mid_s_wdata", s_wdata, 0);
      check("mid_rom_addr", rom_addr, 0);
      check("mid_out_addr", out_addr, 0);
      check("mid_out_data", out_data, 0);
      b_sw = swr_log.size(); b_out = out_log.size();
      repeat (20) @(posedge clk);
      #1;
      check("mid_no_swr", swr_log.size() - b_sw, 0);
      check("mid_no_owr", out_log.size() - b_out, 0);
      check("mid_idle_busy", busy, 0);
      compute_ref();
      b_sw = swr_log.size(); b_out = out_log.size();
      run(1'b0, lat);
      check("mid_rerun_latency", lat, LAT);
      verify("mid_rerun", b_sw, b_out);

      // random S and ROM, start held high for the whole run
      set_random_perm();
      for (int n = 0; n < ML; n++) rom[n] = 8'($urandom);
      load_s();
      compute_ref();
      b_sw = swr_log.size(); b_out = out_log.size();
      run(1'b1, lat);
      check("hold_latency", lat, LAT);
      repeat (15) @(posedge clk);
      #1;
      check("hold_done_kept", done, 1);
      check("hold_no_restart", busy, 0);
      verify("hold", b_sw, b_out);
      check_perm("hold");
      @(negedge clk); start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("done_held_low", done, 1);

      // second run accepted from DONE, continuing from the current S
      compute_ref();
      b_sw = swr_log.size(); b_out = out_log.size();
      run(1'b0, lat);
      check("rerun_latency", lat, LAT);
      verify("rerun", b_sw, b_out);
      check_perm("rerun");

      // fresh random permutation and ROM
      set_random_perm();
      for (int n = 0; n < ML; n++) rom[n] = 8'($urandom);
      load_s();
      compute_ref();
      b_sw = swr_log.size(); b_out = out_log.size();
      run(1'b0, lat);
      check("rand_latency", lat, LAT);
      verify("rand", b_sw, b_out);
      check_perm("rand");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
